// File: rtl/text_writer_if.sv
// Byte-stream handshake and character-buffer port A signals for text_writer.
// The master sources bytes and attributes; the slave (text_writer) drives port A.
interface text_writer_if;
  logic        valid;
  logic        ready;
  logic [7:0]  data;
  logic        attr_we;
  logic [7:0]  attr;
  logic        cea;
  logic [10:0] ada;
  logic [15:0] din;
  logic [5:0]  cur_x;
  logic [4:0]  cur_y;
  logic        busy;

  modport master (
    output valid, data, attr_we, attr,
    input  ready, cea, ada, din, cur_x, cur_y, busy
  );

  modport slave (
    input  valid, data, attr_we, attr,
    output ready, cea, ada, din, cur_x, cur_y, busy
  );
endinterface

// File: rtl/text_writer.sv
// Terminal-style writer for port A of the 64x32 character buffer: places printable
// bytes at a wrapping cursor, handles LF/CR/BS and a full-buffer clear on FF.
module text_writer #(
  parameter int unsigned COLS           = 60,
  parameter int unsigned ROWS           = 17,
  parameter logic [7:0]  ATTR_RESET     = 8'h07,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  text_writer_if.slave bus
);

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  localparam logic [5:0]  ColMax    = 6'(COLS - 1);
  localparam logic [4:0]  RowMax    = 5'(ROWS - 1);
  localparam logic [10:0] LastAddr  = 11'h7FF;
  localparam state_e      StAtReset = CLEAR_ON_RESET ? StClear : StIdle;

  state_e      state_q;
  logic        ready_q;
  logic        busy_q;
  logic        cea_q;
  logic [10:0] ada_q;
  logic [15:0] din_q;
  logic [5:0]  cur_x_q;
  logic [4:0]  cur_y_q;
  logic [7:0]  attr_q;
  logic [7:0]  fill_q;
  logic [4:0]  row_next;

  always_comb begin
    row_next = (cur_y_q == RowMax) ? 5'd0 : cur_y_q + 5'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAtReset;
      ready_q <= !CLEAR_ON_RESET;
      busy_q  <= CLEAR_ON_RESET;
      cea_q   <= 1'b0;
      ada_q   <= '0;
      din_q   <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      attr_q  <= ATTR_RESET;
      fill_q  <= ATTR_RESET;
    end else begin
      cea_q <= 1'b0;
      // Bytes accepted this cycle still see attr_q before the load takes effect.
      if (bus.attr_we) attr_q <= bus.attr;

      unique case (state_q)
        StIdle: begin
          if (bus.valid) begin
            case (bus.data)
              8'h0A: begin
                cur_x_q <= '0;
                cur_y_q <= row_next;
              end
              8'h0D: cur_x_q <= '0;
              8'h08: begin
                if (cur_x_q != 6'd0) begin
                  cur_x_q <= cur_x_q - 6'd1;
                  cea_q   <= 1'b1;
                  ada_q   <= {cur_y_q, cur_x_q - 6'd1};
                  din_q   <= {attr_q, 8'h20};
                end
              end
              8'h0C: begin
                // First fill goes out immediately so the sweep takes 2048 cycles.
                state_q <= StClear;
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
                fill_q  <= attr_q;
                cea_q   <= 1'b1;
                ada_q   <= '0;
                din_q   <= {attr_q, 8'h20};
              end
              default: begin
                cea_q <= 1'b1;
                ada_q <= {cur_y_q, cur_x_q};
                din_q <= {attr_q, bus.data};
                if (cur_x_q == ColMax) begin
                  cur_x_q <= '0;
                  cur_y_q <= row_next;
                end else begin
                  cur_x_q <= cur_x_q + 6'd1;
                end
              end
            endcase
          end
        end
        StClear: begin
          if (!cea_q) begin
            // Entry straight from reset: no write issued yet.
            cea_q <= 1'b1;
            ada_q <= '0;
            din_q <= {fill_q, 8'h20};
          end else if (ada_q == LastAddr) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            cur_x_q <= '0;
            cur_y_q <= '0;
          end else begin
            cea_q <= 1'b1;
            ada_q <= ada_q + 11'd1;
            din_q <= {fill_q, 8'h20};
          end
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.cea   = cea_q;
  assign bus.ada   = ada_q;
  assign bus.din   = din_q;
  assign bus.cur_x = cur_x_q;
  assign bus.cur_y = cur_y_q;

endmodule

// File: tb/tb_text_writer.sv
// Randomized self-checking bench for text_writer against a cursor/write-list model.
module tb_text_writer;
  localparam int COLS = 60;
  localparam int ROWS = 17;

  typedef struct packed {
    logic [31:0] cyc;
    logic [10:0] ada;
    logic [15:0] din;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] cyc = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  text_writer_if w ();

  text_writer #(
    .COLS(COLS), .ROWS(ROWS), .ATTR_RESET(8'h07), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (w.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wr_t got_q[$];
  wr_t exp_q[$];
  always @(negedge clk) if (w.cea === 1'b1) got_q.push_back(wr_t'{cyc, w.ada, w.din});

  // Reference model: cursor position, attribute, expected write list.
  int mx = 0, my = 0;
  logic [7:0] mattr = 8'h07;
  logic [31:0] last_acc;

  task automatic model_byte(input logic [7:0] b, input logic [31:0] c);
    case (b)
      8'h0A: begin mx = 0; my = (my + 1) % ROWS; end
      8'h0D: mx = 0;
      8'h08: if (mx > 0) begin
        mx = mx - 1;
        exp_q.push_back(wr_t'{c, 11'(my * 64 + mx), {mattr, 8'h20}});
      end
      8'h0C: begin
        for (int i = 0; i < 2048; i++) exp_q.push_back(wr_t'{c + 32'(i), 11'(i), {mattr, 8'h20}});
        mx = 0; my = 0;
      end
      default: begin
        exp_q.push_back(wr_t'{c, 11'(my * 64 + mx), {mattr, b}});
        mx = mx + 1;
        if (mx == COLS) begin mx = 0; my = (my + 1) % ROWS; end
      end
    endcase
  endtask

  task automatic send(input logic [7:0] b, input logic we, input logic [7:0] a);
    @(negedge clk);
    w.valid = 1'b1; w.data = b; w.attr_we = we; w.attr = a;
    last_acc = cyc + 1;
    model_byte(b, cyc + 1);
    if (we) mattr = a;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    @(negedge clk);
    w.valid = 1'b0; w.attr_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic load_attr(input logic [7:0] a);
    @(negedge clk);
    w.valid = 1'b0; w.attr_we = 1'b1; w.attr = a;
    mattr = a;
    @(posedge clk); #1;
    w.attr_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    w.valid = 1'b0; w.data = '0; w.attr_we = 1'b0; w.attr = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({w.ready, w.busy, w.cea, w.ada, w.din, w.cur_x, w.cur_y} !== {1'b0, 1'b1, 1'b0, 11'd0,
        16'd0, 6'd0, 5'd0}) begin
      miscompares++;
      $display("FAIL reset_values got rdy=%b busy=%b cea=%b ada=%0d din=%h x=%0d y=%0d exp 0 1 0 0 0 0 0",
               w.ready, w.busy, w.cea, w.ada, w.din, w.cur_x, w.cur_y);
    end
    got_q.delete(); exp_q.delete();
    r = cyc;
    rst_n = 1'b1;
    model_byte(8'h0C, r + 1);
    for (int k = 0; k < 4000 && w.ready !== 1'b1; k++) @(negedge clk);
    vectors++;
    if (cyc !== r + 2049 || w.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_clear_done got cyc=%0d rdy=%b exp cyc=%0d rdy=1", cyc - r, w.ready, 2049);
    end
    vectors++;
    if ({w.cur_y, w.cur_x, w.busy} !== {5'd0, 6'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_cursor got (%0d,%0d) busy=%b exp (0,0) busy=0", w.cur_x, w.cur_y, w.busy);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL reset_write_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL reset_write[%0d] got cyc=%0d ada=%0d din=%h exp cyc=%0d ada=%0d din=%h", i,
                 got_q[i].cyc, got_q[i].ada, got_q[i].din, exp_q[i].cyc, exp_q[i].ada, exp_q[i].din);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    load_attr(8'h1E);
    send(8'h41, 1'b0, 8'h00);
    vectors++;
    if (w.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready got %b exp 1", w.ready);
    end
    send(8'h42, 1'b0, 8'h00);
    idle();
    vectors++;
    if ({w.cur_y, w.cur_x} !== {5'd0, 6'd2} || w.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_cursor got (%0d,%0d) rdy=%b exp (2,0) rdy=1", w.cur_x, w.cur_y, w.ready);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (got_q.size() != 2 || exp_q.size() != 2) begin
      miscompares++;
      $display("FAIL b2b_write_count got %0d exp 2", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL b2b_write[%0d] got cyc=%0d ada=%0d din=%h exp cyc=%0d ada=%0d din=%h", i,
                 got_q[i].cyc, got_q[i].ada, got_q[i].din, exp_q[i].cyc, exp_q[i].ada, exp_q[i].din);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_wrap();
    send(8'h0C, 1'b0, 8'h00);
    idle();
    for (int k = 0; k < 4000 && w.ready !== 1'b1; k++) @(negedge clk);
    vectors++;
    if (cyc !== last_acc + 2048) begin
      miscompares++;
      $display("FAIL clear_ready_time got %0d exp 2048 cycles after accept", cyc - last_acc);
    end
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A, 1'b0, 8'h00);
    vectors++;
    if ({w.cur_y, w.cur_x} !== {5'd16, 6'd0}) begin
      miscompares++;
      $display("FAIL wrap_start got (%0d,%0d) exp (0,16)", w.cur_x, w.cur_y);
    end
    for (int i = 0; i < COLS; i++) send(8'($urandom_range(8'h21, 8'h7E)), 1'b0, 8'h00);
    vectors++;
    if ({w.cur_y, w.cur_x} !== {5'd0, 6'd0} || w.ada !== {5'd16, 6'd59}) begin
      miscompares++;
      $display("FAIL wrap_end got (%0d,%0d) ada=%h exp (0,0) ada=%h", w.cur_x, w.cur_y, w.ada,
               {5'd16, 6'd59});
    end
    send(8'h5A, 1'b0, 8'h00);
    idle();
    vectors++;
    if (w.ada !== 11'd0 || {w.cur_y, w.cur_x} !== {5'd0, 6'd1}) begin
      miscompares++;
      $display("FAIL wrap_next got ada=%0d (%0d,%0d) exp ada=0 (1,0)", w.ada, w.cur_x, w.cur_y);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL wrap_write_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL wrap_write[%0d] got cyc=%0d ada=%0d din=%h exp cyc=%0d ada=%0d din=%h", i,
                 got_q[i].cyc, got_q[i].ada, got_q[i].din, exp_q[i].cyc, exp_q[i].ada, exp_q[i].din);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_controls();
    logic [7:0] seq [4];
    logic [10:0] exp_pos [4];
    seq = '{8'h08, 8'h0D, 8'h0A, 8'h08};
    exp_pos = '{{5'd3, 6'd4}, {5'd3, 6'd0}, {5'd4, 6'd0}, {5'd4, 6'd0}};
    send(8'h0D, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) send(8'h0A, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) send(8'h78, 1'b0, 8'h00);
    vectors++;
    if ({w.cur_y, w.cur_x} !== {5'd3, 6'd5}) begin
      miscompares++;
      $display("FAIL ctl_setup got (%0d,%0d) exp (5,3)", w.cur_x, w.cur_y);
    end
    for (int i = 0; i < 4; i++) begin
      send(seq[i], 1'b0, 8'h00);
      vectors++;
      if ({w.cur_y, w.cur_x} !== exp_pos[i] || w.cea !== (i == 0)) begin
        miscompares++;
        $display("FAIL ctl_%h got pos=%h cea=%b exp pos=%h cea=%b", seq[i], {w.cur_y, w.cur_x},
                 w.cea, exp_pos[i], i == 0);
      end
    end
    idle();
    repeat (2) @(negedge clk);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL ctl_write_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL ctl_write[%0d] got cyc=%0d ada=%0d din=%h exp cyc=%0d ada=%0d din=%h", i,
                 got_q[i].cyc, got_q[i].ada, got_q[i].din, exp_q[i].cyc, exp_q[i].ada, exp_q[i].din);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_attr();
    send(8'h41, 1'b1, 8'h4F);
    send(8'h42, 1'b0, 8'h00);
    send(8'h0C, 1'b0, 8'h00);
    idle();
    repeat (100) @(negedge clk);
    load_attr(8'($urandom_range(0, 255)));
    vectors++;
    if (w.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL attr_busy got %b exp 1", w.busy);
    end
    for (int k = 0; k < 4000 && w.ready !== 1'b1; k++) @(negedge clk);
    vectors++;
    if (cyc !== last_acc + 2048 || {w.cur_y, w.cur_x} !== 11'd0) begin
      miscompares++;
      $display("FAIL attr_clear_done got %0d cycles pos=%h exp 2048 pos=0", cyc - last_acc,
               {w.cur_y, w.cur_x});
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL attr_write_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL attr_write[%0d] got cyc=%0d ada=%0d din=%h exp cyc=%0d ada=%0d din=%h", i,
                 got_q[i].cyc, got_q[i].ada, got_q[i].din, exp_q[i].cyc, exp_q[i].ada, exp_q[i].din);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0: b = 8'h0A;
        1: b = 8'h0D;
        2, 3: b = 8'h08;
        default: begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'h0C) b = 8'h2E;
        end
      endcase
      if ($urandom_range(0, 7) == 0) idle();
      send(b, 1'($urandom_range(0, 4) == 0), 8'($urandom));
      vectors++;
      if ({w.cur_y, w.cur_x} !== {5'(my), 6'(mx)}) begin
        miscompares++;
        $display("FAIL rand_cursor[%0d] byte=%h got (%0d,%0d) exp (%0d,%0d)", n, b, w.cur_x,
                 w.cur_y, mx, my);
      end
    end
    idle();
    repeat (2) @(negedge clk);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL rand_write_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL rand_write[%0d] got cyc=%0d ada=%0d din=%h exp cyc=%0d ada=%0d din=%h", i,
                 got_q[i].cyc, got_q[i].ada, got_q[i].din, exp_q[i].cyc, exp_q[i].ada, exp_q[i].din);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_clear();
    logic [31:0] r;
    send(8'h0C, 1'b0, 8'h00);
    idle();
    for (int k = 0; k < 3000 && !(w.cea === 1'b1 && w.ada === 11'd1000); k++) @(negedge clk);
    vectors++;
    if (w.ada !== 11'd1000) begin
      miscompares++;
      $display("FAIL midclr_reach got ada=%0d exp 1000", w.ada);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({w.cea, w.ready, w.busy, w.ada, w.cur_x, w.cur_y} !== {1'b0, 1'b0, 1'b1, 11'd0, 6'd0,
        5'd0}) begin
      miscompares++;
      $display("FAIL midclr_async got cea=%b rdy=%b busy=%b ada=%0d exp cea=0 rdy=0 busy=1 ada=0",
               w.cea, w.ready, w.busy, w.ada);
    end
    repeat (3) @(negedge clk);
    got_q.delete(); exp_q.delete();
    mx = 0; my = 0; mattr = 8'h07;
    r = cyc;
    rst_n = 1'b1;
    model_byte(8'h0C, r + 1);
    for (int k = 0; k < 4000 && w.ready !== 1'b1; k++) @(negedge clk);
    vectors++;
    if (cyc !== r + 2049) begin
      miscompares++;
      $display("FAIL midclr_done got %0d cycles exp 2049", cyc - r);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL midclr_write_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL midclr_write[%0d] got cyc=%0d ada=%0d din=%h exp cyc=%0d ada=%0d din=%h", i,
                 got_q[i].cyc, got_q[i].ada, got_q[i].din, exp_q[i].cyc, exp_q[i].ada, exp_q[i].din);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wrap();
    test_controls();
    test_attr();
    test_random();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
